// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals shared by the arbiter and its environment.
// The arbiter connects through the slave modport; the requester/memory model uses master.
interface mem_port_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_ack;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        arb_busy;
    logic        arb_err;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_rdata, mem_ready,
        output fetch_rdata, fetch_ack, data_rdata, data_ack,
               mem_en, mem_we, mem_addr, mem_wdata, arb_busy, arb_err
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_rdata, mem_ready,
        input  fetch_rdata, fetch_ack, data_rdata, data_ack,
               mem_en, mem_we, mem_addr, mem_wdata, arb_busy, arb_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with wait timeout; grant one cycle after request,
// completion acked one cycle after mem_ready. RR_ARB_EN selects round-robin instead of data-first priority.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_F = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_fetch_rdata;
    logic [31:0] r_data_rdata;
    logic        r_fetch_ack;
    logic        r_data_ack;
    logic        r_err;
`ifdef RR_ARB_EN
    logic        r_last_d;
`endif

    logic w_busy;
    logic w_expire;
    logic w_pick_d;
    logic w_grant_d;
    logic w_grant_f;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_expire = (r_cnt == TIMEOUT_LAST);

    // The winner is chosen from the raw requests; a winner whose ack is still
    // pulsing is simply not granted this cycle, so a held high-priority request
    // keeps blocking the lower-priority one instead of letting it slip in.
    always_comb begin
        w_pick_d = bus.data_req;
`ifdef RR_ARB_EN
        if (bus.data_req && bus.fetch_req) begin
            w_pick_d = ~r_last_d;
        end
`endif
        w_grant_d = w_pick_d && !r_data_ack;
        w_grant_f = !w_pick_d && bus.fetch_req && !r_fetch_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_we          <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_fetch_rdata <= 32'd0;
            r_data_rdata  <= 32'd0;
            r_fetch_ack   <= 1'b0;
            r_data_ack    <= 1'b0;
            r_err         <= 1'b0;
`ifdef RR_ARB_EN
            r_last_d      <= 1'b0;
`endif
        end else begin
            r_fetch_ack <= 1'b0;
            r_data_ack  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state <= ST_GRANT_D;
                        r_we    <= bus.data_we;
                        r_addr  <= bus.data_addr;
                        r_wdata <= bus.data_wdata;
                        r_cnt   <= 8'd0;
`ifdef RR_ARB_EN
                        r_last_d <= 1'b1;
`endif
                    end else if (w_grant_f) begin
                        r_state <= ST_GRANT_F;
                        r_we    <= 1'b0;
                        r_addr  <= bus.fetch_addr;
                        r_cnt   <= 8'd0;
`ifdef RR_ARB_EN
                        r_last_d <= 1'b0;
`endif
                    end
                end
                ST_GRANT_F, ST_GRANT_D: begin
                    if (bus.mem_ready) begin
                        r_state <= ST_IDLE;
                        if (r_state == ST_GRANT_F) begin
                            r_fetch_rdata <= bus.mem_rdata;
                            r_fetch_ack   <= 1'b1;
                        end else begin
                            r_data_ack <= 1'b1;
                            if (!r_we) begin
                                r_data_rdata <= bus.mem_rdata;
                            end
                        end
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= r_cnt + 8'd1;
                        r_err   <= 1'b1;
                        if (r_state == ST_GRANT_F) begin
                            r_fetch_ack <= 1'b1;
                        end else begin
                            r_data_ack <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en      = w_busy;
    assign bus.mem_we      = w_busy && r_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.arb_busy    = w_busy;
    assign bus.arb_err     = r_err;
    assign bus.fetch_rdata = r_fetch_rdata;
    assign bus.fetch_ack   = r_fetch_ack;
    assign bus.data_rdata  = r_data_rdata;
    assign bus.data_ack    = r_data_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single-transaction traffic compared against an expected-winner / expected-duration model.
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_frd;
    logic [31:0] exp_drd;
    logic [31:0] exp_mwd;
    bit          last_d;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".mem_en"},   32'(bus.mem_en),   32'd0);
        chk({tag, ".mem_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, ".arb_busy"}, 32'(bus.arb_busy), 32'd0);
    endtask

    function automatic bit winner_is_data(input bit fr, input bit dr);
`ifdef RR_ARB_EN
        return (fr && dr) ? !last_d : dr;
`else
        return dr;
`endif
    endfunction

    // One complete transaction starting from a quiet IDLE. d = idle-ready cycles before
    // mem_ready; d >= TMO means mem_ready never comes and the timeout must fire.
    task automatic run_txn(input bit fr, input bit dr, input bit we,
                           input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                           input int d, input logic [31:0] rd, input bit drop);
        bit          win_d;
        bit          tmo_hit;
        int          n;
        logic [31:0] ea;
        win_d = winner_is_data(fr, dr);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.data_req   = dr;
        bus.data_we    = we;
        bus.data_addr  = da;
        bus.data_wdata = wd;
        tick();
        ea = win_d ? da : fa;
        if (win_d) exp_mwd = wd;
        last_d  = win_d;
        tmo_hit = (d >= TMO);
        n       = tmo_hit ? TMO : d + 1;
        for (int c = 0; c < n; c++) begin
            chk("grant.mem_en",    32'(bus.mem_en),    32'd1);
            chk("grant.arb_busy",  32'(bus.arb_busy),  32'd1);
            chk("grant.mem_we",    32'(bus.mem_we),    32'(win_d && we));
            chk("grant.mem_addr",  bus.mem_addr,       ea);
            chk("grant.mem_wdata", bus.mem_wdata,      exp_mwd);
            chk("grant.acks",      32'({bus.fetch_ack, bus.data_ack, bus.arb_err}), 32'd0);
            if (c == 0 && drop) begin
                bus.fetch_req  = 1'b0;
                bus.data_req   = 1'b0;
                bus.fetch_addr = $urandom;
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            bus.mem_ready = (!tmo_hit && c == d);
            bus.mem_rdata = (c == d) ? rd : $urandom;
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        if (!tmo_hit) begin
            if (!win_d) exp_frd = rd;
            else if (!we) exp_drd = rd;
        end
        chk("done.fetch_ack",   32'(bus.fetch_ack), 32'(!win_d));
        chk("done.data_ack",    32'(bus.data_ack),  32'(win_d));
        chk("done.arb_err",     32'(bus.arb_err),   32'(tmo_hit));
        chk("done.fetch_rdata", bus.fetch_rdata,    exp_frd);
        chk("done.data_rdata",  bus.data_rdata,     exp_drd);
        chk("done.mem_addr",    bus.mem_addr,       ea);
        chk_idle_outputs("done");
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
        tick();
        bus.mem_ready = 1'b0;
        chk("idle.acks", 32'({bus.fetch_ack, bus.data_ack, bus.arb_err}), 32'd0);
        chk_idle_outputs("idle");
    endtask

    initial begin
        string       got;
        string       want;
        int          cyc;
        bit          nd;
        bit          fr;
        bit          dr;
        int          d;
        exp_frd = 32'd0;
        exp_drd = 32'd0;
        exp_mwd = 32'd0;
        last_d  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        bus.mem_rdata  = 32'd0;
        bus.mem_ready  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset.mem_addr",    bus.mem_addr,    32'd0);
        chk("reset.mem_wdata",   bus.mem_wdata,   32'd0);
        chk("reset.fetch_rdata", bus.fetch_rdata, 32'd0);
        chk("reset.data_rdata",  bus.data_rdata,  32'd0);
        chk("reset.acks", 32'({bus.fetch_ack, bus.data_ack, bus.arb_err}), 32'd0);
        reset = 1'b0;
        tick();

        // Directed: fetch with ready two cycles after mem_en, store, timeout, ready on the last count.
        run_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 2, 32'h7880_0003, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 0, 32'hCAFE_0001, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, TMO, 32'hBAD0_BAD0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h48, 32'h0, TMO - 1, 32'h5555_AAAA, 1'b1);
        run_txn(1'b1, 1'b1, 1'b0, 32'h30, 32'h50, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            fr = 1'($urandom);
            dr = 1'($urandom);
            if (!fr && !dr) fr = 1'b1;
            d = $urandom_range(0, TMO + 2);
            run_txn(fr, dr, 1'($urandom), $urandom, $urandom, $urandom, d, $urandom, 1'($urandom));
        end

        // Both requests held continuously with immediate ready: record the first four grants.
        bus.fetch_addr = 32'h100;
        bus.data_addr  = 32'h200;
        bus.data_we    = 1'b0;
        bus.mem_rdata  = 32'hA5A5_0001;
        bus.mem_ready  = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.data_req   = 1'b1;
        got  = "";
        want = "";
        for (int k = 0; k < 4; k++) begin
            nd = winner_is_data(1'b1, 1'b1);
            want = {want, nd ? "D" : "F"};
            if (nd) exp_drd = 32'hA5A5_0001;
            else    exp_frd = 32'hA5A5_0001;
            last_d = nd;
        end
        cyc = 0;
        while (got.len() < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.mem_en === 1'b1) got = {got, (bus.mem_addr == 32'h200) ? "D" : "F"};
        end
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        total++;
        assert (got == want) else begin
            bad++;
            $error("FAIL b2b.order observed=%s expected=%s", got, want);
        end
        chk("b2b.fetch_rdata", bus.fetch_rdata, exp_frd);
        chk("b2b.data_rdata",  bus.data_rdata,  exp_drd);
        chk_idle_outputs("b2b");

        // Reset arriving in the third GRANT_D cycle aborts the load with no ack.
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 32'h60;
        tick();
        chk("rst.granted", 32'(bus.mem_en), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        reset = 1'b0;
        bus.data_req = 1'b0;
        chk_idle_outputs("rst");
        chk("rst.mem_addr",    bus.mem_addr,    32'd0);
        chk("rst.mem_wdata",   bus.mem_wdata,   32'd0);
        chk("rst.fetch_rdata", bus.fetch_rdata, 32'd0);
        chk("rst.data_rdata",  bus.data_rdata,  32'd0);
        chk("rst.acks", 32'({bus.fetch_ack, bus.data_ack, bus.arb_err}), 32'd0);
        tick();
        chk("rst.late_ack", 32'({bus.fetch_ack, bus.data_ack, bus.arb_err}), 32'd0);
        exp_frd = 32'd0;
        exp_drd = 32'd0;
        exp_mwd = 32'd0;
        last_d  = 1'b0;
        run_txn(1'b1, 1'b1, 1'b1, 32'h70, 32'h80, 32'h0102_0304, 4, 32'h9999_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
